// File: rtl/mem_bist_initiator_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_bist_initiator_if
// Brief    : valid/ready single-port memory request bus between BIST and memory
// Revision : 1.0  initial release
// ============================================================================
interface mem_bist_initiator_if #(
   parameter int WIDTH      = 8,
   parameter int ADDR_WIDTH = 3
);
   logic                  valid;
   logic                  wr_rd;
   logic [ADDR_WIDTH-1:0] addr;
   logic [WIDTH-1:0]      wdata;
   logic                  ready;
   logic [WIDTH-1:0]      rdata;

   modport master (
      output valid, wr_rd, addr, wdata,
      input  ready, rdata
   );

   modport slave (
      input  valid, wr_rd, addr, wdata,
      output ready, rdata
   );
endinterface
`default_nettype wire

// File: rtl/mem_bist_initiator.sv
`default_nettype none
// ============================================================================
// Module   : mem_bist_initiator
// Brief    : four-phase march BIST requester (write P, read P, write ~P, read ~P)
// Revision : 1.0  initial release
// ============================================================================
module mem_bist_initiator #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 8,
   parameter int ADDR_WIDTH = $clog2(DEPTH),
   parameter int TIMEOUT    = 15
) (
   input  wire                    clk_i,
   input  wire                    rst_ni,
   input  wire                    start_i,
   input  wire  [WIDTH-1:0]       seed_i,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   pass_o,
   output logic [ADDR_WIDTH+1:0]  err_cnt_o,
   output logic [ADDR_WIDTH-1:0]  first_err_addr_o,
   output logic                   timeout_err_o,
   mem_bist_initiator_if.master   mem_if
);

   localparam int                    CNT_W     = $clog2(TIMEOUT + 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
   localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_GAP   = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_q;
   logic [1:0]            phase_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WIDTH-1:0]      seed_q;
   logic                  valid_q;
   logic                  wr_rd_q;
   logic [WIDTH-1:0]      wdata_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  pass_q;
   logic                  timeout_q;
   logic [ADDR_WIDTH+1:0] err_cnt_q;
   logic [ADDR_WIDTH-1:0] first_err_q;
   logic [CNT_W-1:0]      wait_cnt_q;

   logic [1:0]            phase_d;
   logic [ADDR_WIDTH-1:0] addr_d;
   logic [WIDTH-1:0]      wdata_d;
   logic [WIDTH-1:0]      expect_data;
   logic                  last_addr;
   logic                  mismatch;
   logic                  abort;

   // Write data for a given phase/address; read phases drive zero.
   function automatic logic [WIDTH-1:0] pattern_for(
      input logic [WIDTH-1:0]      seed,
      input logic [1:0]            phase,
      input logic [ADDR_WIDTH-1:0] a
   );
      logic [WIDTH-1:0] p;
      p = seed + WIDTH'(a);
      case (phase)
         2'd0:    pattern_for = p;
         2'd2:    pattern_for = ~p;
         default: pattern_for = '0;
      endcase
   endfunction

   always_comb begin
      last_addr   = (addr_q == LAST_ADDR);
      phase_d     = last_addr ? phase_q + 2'd1 : phase_q;
      addr_d      = last_addr ? '0 : addr_q + ADDR_WIDTH'(1);
      wdata_d     = pattern_for(seed_q, phase_d, addr_d);
      expect_data = seed_q + WIDTH'(addr_q);
      if (phase_q[1]) begin
         expect_data = ~expect_data;
      end
      mismatch    = (mem_if.rdata != expect_data);
      // A handshake wait that has run out of budget in either bus state.
      abort       = (wait_cnt_q == CNT_LAST) &&
                    (((state_q == S_ISSUE) && !mem_if.ready) ||
                     ((state_q == S_GAP)   &&  mem_if.ready));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         phase_q     <= '0;
         addr_q      <= '0;
         seed_q      <= '0;
         valid_q     <= 1'b0;
         wr_rd_q     <= 1'b0;
         wdata_q     <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         timeout_q   <= 1'b0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         wait_cnt_q  <= '0;
      end else if (abort) begin
         timeout_q  <= 1'b1;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b1;
         pass_q     <= 1'b0;
         wait_cnt_q <= '0;
         state_q    <= S_DONE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start_i) begin
                  seed_q      <= seed_i;
                  err_cnt_q   <= '0;
                  first_err_q <= '0;
                  pass_q      <= 1'b0;
                  timeout_q   <= 1'b0;
                  phase_q     <= 2'd0;
                  addr_q      <= '0;
                  wr_rd_q     <= 1'b1;
                  wdata_q     <= pattern_for(seed_i, 2'd0, '0);
                  valid_q     <= 1'b1;
                  busy_q      <= 1'b1;
                  wait_cnt_q  <= '0;
                  state_q     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (mem_if.ready) begin
                  if (phase_q[0] && mismatch) begin
                     err_cnt_q <= err_cnt_q + (ADDR_WIDTH+2)'(1);
                     if (err_cnt_q == '0) begin
                        first_err_q <= addr_q;
                     end
                  end
                  valid_q    <= 1'b0;
                  wait_cnt_q <= '0;
                  state_q    <= S_GAP;
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end
            S_GAP: begin
               // The memory keeps ready high one cycle past valid; wait it out.
               if (!mem_if.ready) begin
                  wait_cnt_q <= '0;
                  if (last_addr && (phase_q == 2'd3)) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     pass_q  <= (err_cnt_q == '0) && !timeout_q;
                     state_q <= S_DONE;
                  end else begin
                     phase_q <= phase_d;
                     addr_q  <= addr_d;
                     wr_rd_q <= ~phase_d[0];
                     wdata_q <= wdata_d;
                     valid_q <= 1'b1;
                     state_q <= S_ISSUE;
                  end
               end else begin
                  wait_cnt_q <= wait_cnt_q + CNT_W'(1);
               end
            end
            S_DONE: begin
               done_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy_o           = busy_q;
   assign done_o           = done_q;
   assign pass_o           = pass_q;
   assign err_cnt_o        = err_cnt_q;
   assign first_err_addr_o = first_err_q;
   assign timeout_err_o    = timeout_q;
   assign mem_if.valid     = valid_q;
   assign mem_if.wr_rd     = wr_rd_q;
   assign mem_if.addr      = addr_q;
   assign mem_if.wdata     = wdata_q;

endmodule
`default_nettype wire
